// File: rtl/sap1_pkg.sv
// Shared constants for the SAP-1 controller: opcodes, one-hot T-states and control-word bit indices.
// Optional build macro SAP1_SINGLE_STEP_EN is consumed by the interface and the top, not here.
package sap1_pkg;

  localparam int T_STATES = 6;
  localparam int OPCODE_W = 4;

  localparam logic [OPCODE_W-1:0] OP_LDA = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_ADD = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_SUB = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_OUT = 4'hE;
  localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;

  typedef enum logic [T_STATES-1:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  localparam int CW_PC_SEND  = 0;
  localparam int CW_PC_INC   = 1;
  localparam int CW_MAR_LOAD = 2;
  localparam int CW_RAM_SEND = 3;
  localparam int CW_IR_LOAD  = 4;
  localparam int CW_IR_SEND  = 5;
  localparam int CW_A_LOAD   = 6;
  localparam int CW_A_SEND   = 7;
  localparam int CW_B_LOAD   = 8;
  localparam int CW_ALU_SEND = 9;
  localparam int CW_ALU_SUB  = 10;
  localparam int CW_OUT_LOAD = 11;
  localparam int CW_W        = 12;

  typedef logic [CW_W-1:0] cw_t;

endpackage

// File: rtl/sap1_controller_if.sv
// Control bus between the SAP-1 sequencer (master) and the datapath (slave).
// SAP1_SINGLE_STEP_EN adds the step input.
interface sap1_controller_if;
  import sap1_pkg::*;

  logic                run;
  logic [OPCODE_W-1:0] opcode;
`ifdef SAP1_SINGLE_STEP_EN
  logic                step;
`endif
  logic                pc_send;
  logic                pc_inc;
  logic                mar_load;
  logic                ram_send;
  logic                ir_load;
  logic                ir_send;
  logic                a_load;
  logic                a_send;
  logic                b_load;
  logic                alu_send;
  logic                alu_sub;
  logic                out_load;
  logic [T_STATES-1:0] t_state;
  logic                halted;

  // Strobes are level signals: the target register samples on the rising edge that ends the cycle.
  modport master (
`ifdef SAP1_SINGLE_STEP_EN
    input  step,
`endif
    input  run, opcode,
    output pc_send, pc_inc, mar_load, ram_send, ir_load, ir_send, a_load, a_send,
    output b_load, alu_send, alu_sub, out_load, t_state, halted
  );

  modport slave (
`ifdef SAP1_SINGLE_STEP_EN
    output step,
`endif
    output run, opcode,
    input  pc_send, pc_inc, mar_load, ram_send, ir_load, ir_send, a_load, a_send,
    input  b_load, alu_send, alu_sub, out_load, t_state, halted
  );

endinterface

// File: rtl/sap1_ring_counter.sv
// One-hot T-state ring T1..T6: resets to T1, rotates by one position when advance_i is high.
module sap1_ring_counter
  import sap1_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     advance_i,
  output t_state_e t_state_o
);

  t_state_e t_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      t_q <= T1;
    end else if (advance_i) begin
      t_q <= t_state_e'({t_q[T_STATES-2:0], t_q[T_STATES-1]});
    end
  end

  assign t_state_o = t_q;

endmodule

// File: rtl/sap1_controller.sv
// SAP-1 controller-sequencer: T-state ring, opcode decode into bus strobes, sticky halt flag.
// Build option SAP1_SINGLE_STEP_EN: advance one T-state per rising edge of bus.step.
module sap1_controller
  import sap1_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  sap1_controller_if.master   bus
);

  t_state_e t_state;
  logic     halted_q;
  logic     step_ok;
  logic     advance;
  logic     strobe_en;
  cw_t      cw;

`ifdef SAP1_SINGLE_STEP_EN
  logic step_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_q <= 1'b0;
    end else begin
      step_q <= bus.step;
    end
  end

  // The edge cycle both shows the current state's strobes and advances, so each state fires exactly once.
  assign step_ok = bus.step & ~step_q;
`else
  assign step_ok = 1'b1;
`endif

  assign advance   = bus.run & ~halted_q & step_ok;
  assign strobe_en = rst & advance;

  sap1_ring_counter u_ring (
    .clk       (clk),
    .rst       (rst),
    .advance_i (advance),
    .t_state_o (t_state)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halted_q <= 1'b0;
    end else if (advance && (t_state == T4) && (bus.opcode == OP_HLT)) begin
      halted_q <= 1'b1;
    end
  end

  always_comb begin
    cw = '0;
    case (t_state)
      T1: begin
        cw[CW_PC_SEND]  = 1'b1;
        cw[CW_MAR_LOAD] = 1'b1;
      end
      T2: cw[CW_PC_INC] = 1'b1;
      T3: begin
        cw[CW_RAM_SEND] = 1'b1;
        cw[CW_IR_LOAD]  = 1'b1;
      end
      T4: begin
        if (bus.opcode == OP_LDA || bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
          cw[CW_IR_SEND]  = 1'b1;
          cw[CW_MAR_LOAD] = 1'b1;
        end else if (bus.opcode == OP_OUT) begin
          cw[CW_A_SEND]   = 1'b1;
          cw[CW_OUT_LOAD] = 1'b1;
        end
      end
      T5: begin
        if (bus.opcode == OP_LDA) begin
          cw[CW_RAM_SEND] = 1'b1;
          cw[CW_A_LOAD]   = 1'b1;
        end else if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
          cw[CW_RAM_SEND] = 1'b1;
          cw[CW_B_LOAD]   = 1'b1;
          cw[CW_ALU_SUB]  = (bus.opcode == OP_SUB);
        end
      end
      T6: begin
        if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
          cw[CW_ALU_SEND] = 1'b1;
          cw[CW_A_LOAD]   = 1'b1;
          cw[CW_ALU_SUB]  = (bus.opcode == OP_SUB);
        end
      end
      default: cw = '0;
    endcase
    if (!strobe_en) begin
      cw = '0;
    end
  end

  assign bus.pc_send  = cw[CW_PC_SEND];
  assign bus.pc_inc   = cw[CW_PC_INC];
  assign bus.mar_load = cw[CW_MAR_LOAD];
  assign bus.ram_send = cw[CW_RAM_SEND];
  assign bus.ir_load  = cw[CW_IR_LOAD];
  assign bus.ir_send  = cw[CW_IR_SEND];
  assign bus.a_load   = cw[CW_A_LOAD];
  assign bus.a_send   = cw[CW_A_SEND];
  assign bus.b_load   = cw[CW_B_LOAD];
  assign bus.alu_send = cw[CW_ALU_SEND];
  assign bus.alu_sub  = cw[CW_ALU_SUB];
  assign bus.out_load = cw[CW_OUT_LOAD];
  assign bus.t_state  = t_state;
  assign bus.halted   = halted_q;

endmodule

// File: tb/tb_sap1_controller.sv
// Directed bench for sap1_controller in its default build (no single-step port).
module tb_sap1_controller;

  localparam logic [11:0] M_PC_SEND  = 12'h800;
  localparam logic [11:0] M_PC_INC   = 12'h400;
  localparam logic [11:0] M_MAR_LOAD = 12'h200;
  localparam logic [11:0] M_RAM_SEND = 12'h100;
  localparam logic [11:0] M_IR_LOAD  = 12'h080;
  localparam logic [11:0] M_IR_SEND  = 12'h040;
  localparam logic [11:0] M_A_LOAD   = 12'h020;
  localparam logic [11:0] M_A_SEND   = 12'h010;
  localparam logic [11:0] M_B_LOAD   = 12'h008;
  localparam logic [11:0] M_ALU_SEND = 12'h004;
  localparam logic [11:0] M_ALU_SUB  = 12'h002;
  localparam logic [11:0] M_OUT_LOAD = 12'h001;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  sap1_controller_if bus_if ();

  sap1_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  logic [11:0] obs_cw;
  assign obs_cw = {bus_if.pc_send, bus_if.pc_inc, bus_if.mar_load, bus_if.ram_send,
                   bus_if.ir_load, bus_if.ir_send, bus_if.a_load, bus_if.a_send,
                   bus_if.b_load, bus_if.alu_send, bus_if.alu_sub, bus_if.out_load};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus_if.run = 1'b1;
    bus_if.opcode = 4'h0;
    repeat (3) tick();
    n_cmp++;
    if (bus_if.t_state !== 6'b000001) begin
      n_err++; $display("FAIL reset_tstate: got %b want 000001", bus_if.t_state);
    end
    n_cmp++;
    if (obs_cw !== 12'h000) begin
      n_err++; $display("FAIL reset_strobes: got %h want 000", obs_cw);
    end
    n_cmp++;
    if (bus_if.halted !== 1'b0) begin
      n_err++; $display("FAIL reset_halted: got %b want 0", bus_if.halted);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus_if.t_state !== 6'b000001) begin
      n_err++; $display("FAIL release_tstate: got %b want 000001", bus_if.t_state);
    end
    n_cmp++;
    if (obs_cw !== (M_PC_SEND | M_MAR_LOAD)) begin
      n_err++; $display("FAIL release_t1_strobes: got %h want %h", obs_cw, M_PC_SEND | M_MAR_LOAD);
    end
  endtask

  // Runs one full instruction from T1 and compares every T-state against exp.
  task automatic test_instr(input string name, input logic [3:0] op,
                            input logic [11:0] e4, input logic [11:0] e5, input logic [11:0] e6);
    logic [11:0] exp_cw [6];
    logic [5:0]  exp_t;
    exp_cw[0] = M_PC_SEND | M_MAR_LOAD;
    exp_cw[1] = M_PC_INC;
    exp_cw[2] = M_RAM_SEND | M_IR_LOAD;
    exp_cw[3] = e4;
    exp_cw[4] = e5;
    exp_cw[5] = e6;
    bus_if.opcode = op;
    #1;
    for (int i = 0; i < 6; i++) begin
      exp_t = 6'b000001 << i;
      n_cmp++;
      if (bus_if.t_state !== exp_t) begin
        n_err++; $display("FAIL %s_tstate_T%0d: got %b want %b", name, i + 1, bus_if.t_state, exp_t);
      end
      n_cmp++;
      if (obs_cw !== exp_cw[i]) begin
        n_err++; $display("FAIL %s_strobes_T%0d: got %h want %h", name, i + 1, obs_cw, exp_cw[i]);
      end
      tick();
    end
    n_cmp++;
    if (bus_if.t_state !== 6'b000001) begin
      n_err++; $display("FAIL %s_wrap: got %b want 000001", name, bus_if.t_state);
    end
  endtask

  task automatic test_run_gap();
    bus_if.opcode = 4'h0;
    tick();
    tick();
    bus_if.run = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (bus_if.t_state !== 6'b000100 || obs_cw !== 12'h000) begin
        n_err++; $display("FAIL run_gap_hold_%0d: got t=%b cw=%h want t=000100 cw=000", i, bus_if.t_state, obs_cw);
      end
      tick();
    end
    bus_if.run = 1'b1;
    #1;
    n_cmp++;
    if (bus_if.t_state !== 6'b000100 || obs_cw !== (M_RAM_SEND | M_IR_LOAD)) begin
      n_err++; $display("FAIL run_gap_resume: got t=%b cw=%h want t=000100 cw=%h", bus_if.t_state, obs_cw, M_RAM_SEND | M_IR_LOAD);
    end
    tick();
    n_cmp++;
    if (bus_if.t_state !== 6'b001000 || obs_cw !== (M_IR_SEND | M_MAR_LOAD)) begin
      n_err++; $display("FAIL run_gap_next: got t=%b cw=%h want t=001000 cw=%h", bus_if.t_state, obs_cw, M_IR_SEND | M_MAR_LOAD);
    end
    repeat (3) tick();
    n_cmp++;
    if (bus_if.t_state !== 6'b000001) begin
      n_err++; $display("FAIL run_gap_wrap: got %b want 000001", bus_if.t_state);
    end
  endtask

  task automatic test_hlt();
    bus_if.opcode = 4'hF;
    repeat (3) tick();
    n_cmp++;
    if (bus_if.t_state !== 6'b001000 || obs_cw !== 12'h000 || bus_if.halted !== 1'b0) begin
      n_err++; $display("FAIL hlt_t4: got t=%b cw=%h h=%b want t=001000 cw=000 h=0", bus_if.t_state, obs_cw, bus_if.halted);
    end
    tick();
    n_cmp++;
    if (bus_if.halted !== 1'b1) begin
      n_err++; $display("FAIL hlt_set: got %b want 1", bus_if.halted);
    end
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (bus_if.t_state !== 6'b010000 || obs_cw !== 12'h000 || bus_if.halted !== 1'b1) begin
        n_err++; $display("FAIL hlt_frozen_%0d: got t=%b cw=%h h=%b want t=010000 cw=000 h=1", i, bus_if.t_state, obs_cw, bus_if.halted);
      end
      tick();
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus_if.halted !== 1'b0 || bus_if.t_state !== 6'b000001 || obs_cw !== 12'h000) begin
      n_err++; $display("FAIL hlt_reset: got h=%b t=%b cw=%h want h=0 t=000001 cw=000", bus_if.halted, bus_if.t_state, obs_cw);
    end
    bus_if.opcode = 4'h0;
    tick();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus_if.t_state !== 6'b000001 || obs_cw !== (M_PC_SEND | M_MAR_LOAD)) begin
      n_err++; $display("FAIL hlt_restart: got t=%b cw=%h want t=000001 cw=%h", bus_if.t_state, obs_cw, M_PC_SEND | M_MAR_LOAD);
    end
  endtask

  task automatic test_contention();
    logic [3:0] ops [8];
    int         sends;
    logic [5:0] exp_t;
    ops[0] = 4'h0; ops[1] = 4'h1; ops[2] = 4'h2; ops[3] = 4'hE;
    ops[4] = 4'h5; ops[5] = 4'hA; ops[6] = 4'h3; ops[7] = 4'h7;
    for (int k = 0; k < 500; k++) begin
      bus_if.opcode = ops[$urandom_range(0, 7)];
      #1;
      for (int c = 0; c < 6; c++) begin
        sends = int'(bus_if.pc_send) + int'(bus_if.ram_send) + int'(bus_if.ir_send)
              + int'(bus_if.a_send) + int'(bus_if.alu_send);
        exp_t = 6'b000001 << c;
        n_cmp++;
        if (sends > 1 || bus_if.t_state !== exp_t) begin
          n_err++; $display("FAIL contention_i%0d_T%0d: op=%h sends=%0d t=%b want sends<=1 t=%b", k, c + 1, bus_if.opcode, sends, bus_if.t_state, exp_t);
        end
        tick();
      end
    end
  endtask

  initial begin
    bus_if.run = 1'b0;
    bus_if.opcode = 4'h0;
    test_reset();
    test_instr("lda", 4'h0, M_IR_SEND | M_MAR_LOAD, M_RAM_SEND | M_A_LOAD, 12'h000);
    test_instr("add", 4'h1, M_IR_SEND | M_MAR_LOAD, M_RAM_SEND | M_B_LOAD, M_ALU_SEND | M_A_LOAD);
    test_instr("sub", 4'h2, M_IR_SEND | M_MAR_LOAD, M_RAM_SEND | M_B_LOAD | M_ALU_SUB,
               M_ALU_SEND | M_A_LOAD | M_ALU_SUB);
    test_instr("out", 4'hE, M_A_SEND | M_OUT_LOAD, 12'h000, 12'h000);
    test_instr("nop", 4'h5, 12'h000, 12'h000, 12'h000);
    test_run_gap();
    test_hlt();
    test_contention();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
